// File: rtl/cpu_bus_master.sv
// Timed bus master. Each accepted request becomes one SETUP/STROBE/HOLD cycle on the
// BRAM-style CPU bus. The bus is released to IDLE for at least one cycle between transactions.
module cpu_bus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 3,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [1:0]  REQ_SELECT,
    input  logic [13:0] REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [15:0] RSP_RDATA,
    output logic        EN,
    output logic        RD,
    output logic        WE,
    output logic        RDWR,
    output logic [1:0]  BRAM_SELECT,
    output logic [13:0] BRAM_ADDR,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    output logic        BUSY
);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
        $error("SETUP_CYCLES must be in 1..15");
    end
    if (STROBE_CYCLES < 2 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("STROBE_CYCLES must be in 2..15");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        live_q, live_d;   // keeps REQ_READY low until the first edge after reset
    logic        rdwr_q, rdwr_d;
    logic [1:0]  sel_q, sel_d;
    logic [13:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rsp_q, rsp_d;

    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            rdwr_q  <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
            rdwr_q  <= rdwr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        live_d  = 1'b1;
        rdwr_d  = rdwr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rsp_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Direction is only ever latched here, so RDWR cannot flip while EN is high.
                if (REQ_VALID && REQ_READY) begin
                    state_d = SETUP;
                    cnt_d   = 4'(SETUP_CYCLES - 1);
                    rdwr_d  = ~REQ_WRITE;
                    sel_d   = REQ_SELECT;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = 4'(STROBE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = 4'(HOLD_CYCLES - 1);
                    if (rdwr_q) begin
                        rdata_d = DATA_IN;
                        rsp_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign REQ_READY   = (state_q == IDLE) && live_q;
    assign EN          = (state_q != IDLE);
    assign BUSY        = EN;
    assign RD          = (state_q == STROBE) && rdwr_q;
    assign WE          = (state_q == STROBE) && !rdwr_q;
    assign RDWR        = rdwr_q;
    assign DATA_OE     = EN && !rdwr_q;
    assign BRAM_SELECT = sel_q;
    assign BRAM_ADDR   = addr_q;
    assign DATA_OUT    = wdata_q;
    assign RSP_RDATA   = rdata_q;
    assign RSP_VALID   = rsp_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: default timing instance plus a 2/2/3 timing instance.
module tb_cpu_bus_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        v, wr;
    logic [1:0]  sel;
    logic [13:0] addr;
    logic [15:0] wdata, pat;
    logic        ready, rspv, en, rd, we, rdwr, oe, busy;
    logic [1:0]  sel_o;
    logic [13:0] addr_o;
    logic [15:0] dout, rdata, din;

    // Responder model: drives the pattern only while RD is high, noise otherwise.
    assign din = rd ? pat : 16'h0F0F;

    cpu_bus_master u_dut (
        .BUS_CLK(clk), .RST(rst), .REQ_VALID(v), .REQ_READY(ready), .REQ_WRITE(wr),
        .REQ_SELECT(sel), .REQ_ADDR(addr), .REQ_WDATA(wdata), .RSP_VALID(rspv),
        .RSP_RDATA(rdata), .EN(en), .RD(rd), .WE(we), .RDWR(rdwr), .BRAM_SELECT(sel_o),
        .BRAM_ADDR(addr_o), .DATA_OUT(dout), .DATA_OE(oe), .DATA_IN(din), .BUSY(busy)
    );

    logic        v2, wr2;
    logic [1:0]  sel2;
    logic [13:0] addr2;
    logic [15:0] wdata2;
    logic        ready2, rspv2, en2, rd2, we2, rdwr2, oe2, busy2;
    logic [1:0]  sel2_o;
    logic [13:0] addr2_o;
    logic [15:0] dout2, rdata2;
    logic [15:0] din2 = 16'h0000;

    cpu_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(2), .HOLD_CYCLES(3)) u_dut2 (
        .BUS_CLK(clk), .RST(rst), .REQ_VALID(v2), .REQ_READY(ready2), .REQ_WRITE(wr2),
        .REQ_SELECT(sel2), .REQ_ADDR(addr2), .REQ_WDATA(wdata2), .RSP_VALID(rspv2),
        .RSP_RDATA(rdata2), .EN(en2), .RD(rd2), .WE(we2), .RDWR(rdwr2), .BRAM_SELECT(sel2_o),
        .BRAM_ADDR(addr2_o), .DATA_OUT(dout2), .DATA_OE(oe2), .DATA_IN(din2), .BUSY(busy2)
    );

    wire [7:0]  ctl  = {en, rd, we, rdwr, oe, busy, ready, rspv};
    wire [7:0]  ctl2 = {en2, rd2, we2, rdwr2, oe2, busy2, ready2, rspv2};
    wire [47:0] dat  = {sel_o, addr_o, dout, rdata};
    wire [47:0] dat2 = {sel2_o, addr2_o, dout2, rdata2};

    task automatic test_reset();
        #12;
        checks++;
        if ({ctl, dat} !== 56'h0) begin
            errors++; $display("FAIL reset_outputs got ctl=%b dat=%h exp all zero", ctl, dat);
        end
        checks++;
        if ({ctl2, dat2} !== 56'h0) begin
            errors++; $display("FAIL reset_outputs2 got ctl=%b dat=%h exp all zero", ctl2, dat2);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge got %b exp 0", ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({ready, ready2, en} !== 3'b110) begin
            errors++; $display("FAIL ready_after_reset got %b exp 110", {ready, ready2, en});
        end
    endtask

    task automatic test_write();
        logic [7:0] exp;
        logic e_en, e_we;
        @(negedge clk);
        v = 1'b1; wr = 1'b1; sel = 2'd0; addr = 14'h0031; wdata = 16'hBEEF;
        @(posedge clk); #1; v = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            e_en = (k <= 5);
            e_we = (k >= 2 && k <= 4);
            exp  = {e_en, 1'b0, e_we, 1'b0, e_en, e_en, (k == 6), 1'b0};
            checks++;
            if (ctl !== exp) begin
                errors++; $display("FAIL write_ctl t+%0d got %b exp %b", k, ctl, exp);
            end
            checks++;
            if (dat !== {2'd0, 14'h0031, 16'hBEEF, 16'h0000}) begin
                errors++; $display("FAIL write_data t+%0d got %h exp 0031/BEEF/0000", k, dat);
            end
            if (k < 6) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_read();
        logic [7:0] exp;
        logic e_en, e_rd;
        pat = 16'hA5A5;
        @(negedge clk);
        v = 1'b1; wr = 1'b0; sel = 2'd2; addr = 14'h1234; wdata = 16'h1111;
        @(posedge clk); #1; v = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            e_en = (k <= 5);
            e_rd = (k >= 2 && k <= 4);
            exp  = {e_en, e_rd, 1'b0, 1'b1, 1'b0, e_en, (k == 6), (k == 5)};
            checks++;
            if (ctl !== exp) begin
                errors++; $display("FAIL read_ctl t+%0d got %b exp %b", k, ctl, exp);
            end
            checks++;
            if ({sel_o, addr_o, rdata} !== {2'd2, 14'h1234, (k >= 5) ? 16'hA5A5 : 16'h0000}) begin
                errors++; $display("FAIL read_data t+%0d got sel=%0d addr=%h rdata=%h", k, sel_o, addr_o, rdata);
            end
            if (k < 6) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        logic e_en;
        pat = 16'h1357;
        @(negedge clk);
        v = 1'b1; wr = 1'b1; sel = 2'd1; addr = 14'h0100; wdata = 16'h4321;
        @(posedge clk); #1;
        wr = 1'b0; sel = 2'd3; addr = 14'h0200;   // queued read, ignored until ready
        for (int k = 1; k <= 12; k++) begin
            e_en = (k <= 5) || (k >= 7 && k <= 11);
            exp  = {e_en, (k >= 8 && k <= 10), (k >= 2 && k <= 4), (k >= 7), (k <= 5),
                    e_en, (k == 6 || k == 12), (k == 11)};
            checks++;
            if (ctl !== exp) begin
                errors++; $display("FAIL b2b_ctl t+%0d got %b exp %b", k, ctl, exp);
            end
            checks++;
            if ({sel_o, addr_o, rdata} !== ((k >= 7) ? {2'd3, 14'h0200, (k >= 11) ? 16'h1357 : 16'hA5A5}
                                                     : {2'd1, 14'h0100, 16'hA5A5})) begin
                errors++; $display("FAIL b2b_data t+%0d got sel=%0d addr=%h rdata=%h", k, sel_o, addr_o, rdata);
            end
            if (k == 7) v = 1'b0;
            if (k < 12) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_abort();
        pat = 16'hCAFE;
        @(negedge clk);
        v = 1'b1; wr = 1'b0; sel = 2'd1; addr = 14'h0055;
        @(posedge clk); #1; v = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (rd !== 1'b1) begin
            errors++; $display("FAIL abort_in_strobe got rd=%b exp 1", rd);
        end
        #2 rst = 1'b1; #1;
        checks++;
        if ({ctl, dat} !== 56'h0) begin
            errors++; $display("FAIL abort_immediate got ctl=%b dat=%h exp all zero", ctl, dat);
        end
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({en, rd, rspv, ready, rdata} !== {4'b0001, 16'h0000}) begin
                errors++; $display("FAIL abort_after_release edge %0d got en/rd/rspv/ready=%b rdata=%h exp 0001/0000",
                                   k, {en, rd, rspv, ready}, rdata);
            end
        end
    endtask

    task automatic test_timing_params();
        logic [7:0] exp;
        logic e_en;
        @(negedge clk);
        v2 = 1'b1; wr2 = 1'b1; sel2 = 2'd1; addr2 = 14'h3FFF; wdata2 = 16'h0001;
        @(posedge clk); #1; v2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            e_en = (k <= 7);
            exp  = {e_en, 1'b0, (k >= 3 && k <= 4), 1'b0, e_en, e_en, (k == 8), 1'b0};
            checks++;
            if (ctl2 !== exp) begin
                errors++; $display("FAIL params_ctl t+%0d got %b exp %b", k, ctl2, exp);
            end
            checks++;
            if (dat2 !== {2'd1, 14'h3FFF, 16'h0001, 16'h0000}) begin
                errors++; $display("FAIL params_data t+%0d got %h exp 3FFF/0001/0000", k, dat2);
            end
            if (k < 8) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        v = 1'b0; wr = 1'b0; sel = '0; addr = '0; wdata = '0; pat = '0;
        v2 = 1'b0; wr2 = 1'b0; sel2 = '0; addr2 = '0; wdata2 = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_abort();
        test_timing_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
